aes128_inv_cipher_top: RTL and testbench
========================================

# aes128_inv_cipher_top

Iterative AES-128 decryptor (inverse cipher, FIPS-197 §5.3). It is the receive-side counterpart of the existing AES-128 cipher top. It accepts a 128-bit cipher key and ciphertext, derives round key 10 by running the forward key schedule, then walks the schedule backwards one round per cycle alongside the inverse rounds. It sits beside the encryptor in the crypto subsystem and presents the same one-pulse start / one-pulse ready handshake.

## Interface
- No parameters.
- clk_sys  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- cipher_key  input  128  AES key; byte 0 in [127:120].
- cipher_text  input  128  ciphertext block; same byte order.
- decipher_en  input  1  start strobe; sampled only in IDLE.
- plain_text  output  128  registered result; reset 0; held until the next completion.
- plain_ready  output  1  one-cycle completion pulse; reset 0.
- busy  output  1  high in any state other than IDLE; reset 0.

## Operation
- FSM states: IDLE, KEYGEN, ADDK, ROUND.
- IDLE:
  - On decipher_en=1, load key_reg←cipher_key, state_reg←cipher_text, rnd←1.
  - Next state is KEYGEN.
- KEYGEN:
  - Each cycle: key_reg←forward_expand(key_reg, rcon[rnd]), rnd++.
  - After 10 steps key_reg=K10. Next state is ADDK.
- ADDK:
  - state_reg←state_reg^K10.
  - key_reg←inverse_expand(K10, rcon[10])=K9, rnd←9. Next state is ROUND.
- Inverse key step, with current words c0..c3 and previous words p0..p3:
  - p3=c3^c2, p2=c2^c1, p1=c1^c0.
  - p0=c0^SubWord(RotWord(p3))^rcon.
- ROUND, rnd 9..1:
  - state_reg←InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state_reg)), key_reg)).
  - key_reg←inverse_expand(key_reg, rcon[rnd]), rnd--.
- ROUND, rnd=0:
  - Same as above without InvMixColumns.
  - Load plain_text, pulse plain_ready, return to IDLE.
- decipher_en while busy is ignored; no queuing. cipher_key and cipher_text are not sampled after the start edge.
- All GF(2^8) arithmetic uses modulus x^8+x^4+x^3+x+1. rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- Reset mid-operation: FSM returns to IDLE immediately. All outputs and internal registers clear to 0.

## Timing
- Start edge E0 samples decipher_en=1 in IDLE.
- KEYGEN occupies edges E1–E10. ADDK is E11. ROUND occupies E12–E21.
- plain_ready is high in the cycle after E21, for exactly one cycle. Latency is 21 cycles.
- busy rises after E0 and falls after E21.
- decipher_en sampled at E21 (state is ROUND) is ignored. The earliest accepted restart is E22.
- plain_text changes only at completion edges.

## Configuration
- Macro: AES128_INV_KEY_CACHE_EN.
- Defined:
  - Adds registers cached_key (128), cached_k10 (128), cache_valid (1).
  - On completion, store cipher_key→cached_key, K10→cached_k10, and set cache_valid.
  - At start, if cache_valid and cipher_key==cached_key, load key_reg←cached_k10 and go directly to ADDK. Latency becomes 11 cycles.
  - Reset clears cache_valid.
- Undefined: no cache hardware; latency is always 21.

## Structure
- Package aes128_inv_pkg holds:
  - state enum;
  - rcon table;
  - inverse S-box function;
  - xtime and mul-by-9/11/13/14 functions;
  - word and state typedefs.
- The existing forward S-box is reused for both key-schedule directions.
- Sub-module aes128_inv_round: combinational InvShiftRows → InvSubBytes → AddRoundKey → optional InvMixColumns, with a last_round bypass input.
- The top module holds the FSM, round counter, key schedule and output registers.

## Test plan
- FIPS-197 C.1:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Response: pt 00112233445566778899aabbccddeeff, plain_ready exactly 21 cycles after the start edge.
- FIPS-197 Appendix B:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32.
  - Response: pt 3243f6a8885a308d313198a2e0370734. Internal key_reg in ADDK equals d014f9a8c9ee2589e13f0cc8b6630ca6.
- Busy-ignore:
  - Stimulus: pulse decipher_en at cycles 5 and 21 with a different ct.
  - Response: a single plain_ready, with the first result only.
- Reset mid-op:
  - Stimulus: assert rst at cycle 15.
  - Response: busy, plain_ready and plain_text are 0 immediately. A following C.1 run passes with 21-cycle latency.
- Back-to-back:
  - Stimulus: restart at E22 with the B vector after C.1.
  - Response: both results correct. plain_text holds C.1 pt until the second completion.
- With AES128_INV_KEY_CACHE_EN:
  - Stimulus: repeat the C.1 key.
  - Response: second run has 11-cycle latency and the correct pt. A changed key gives 21-cycle latency.

Source files
------------

// File: rtl/aes128_inv_pkg.sv
// Shared types, tables and GF(2^8) helpers for the iterative AES-128 decryptor.
// Holds both key-schedule directions; the forward S-box serves both.
package aes128_inv_pkg;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] state_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_KEYGEN = 2'd1,
        ST_ADDK   = 2'd2,
        ST_ROUND  = 2'd3
    } fsm_e;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[b];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] mul11(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] mul13(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] mul14(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    function automatic word_t sub_rot_word(input word_t w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic state_t fwd_expand(input state_t k, input logic [7:0] rc);
        word_t n0, n1, n2, n3;
        n0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h0};
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0]  ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Undo one schedule step: previous w3 is recovered first since p0 depends on it.
    function automatic state_t inv_expand(input state_t k, input logic [7:0] rc);
        word_t p0, p1, p2, p3;
        p3 = k[31:0]  ^ k[63:32];
        p2 = k[63:32] ^ k[95:64];
        p1 = k[95:64] ^ k[127:96];
        p0 = k[127:96] ^ sub_rot_word(p3) ^ {rc, 24'h0};
        return {p0, p1, p2, p3};
    endfunction

endpackage

// File: rtl/aes128_inv_cipher_top_round.sv
// One combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless i_last_round bypasses it.
module aes128_inv_round
    import aes128_inv_pkg::*;
(
    input  logic [127:0] i_state,
    input  logic [127:0] i_key,
    input  logic         i_last_round,
    output logic [127:0] o_state
);
    // Index 0 is the most significant byte, matching the external byte order.
    logic [0:15][7:0] w_in, w_sr, w_ak, w_mc, w_key;

    assign w_in  = i_state;
    assign w_key = i_key;

    for (genvar gi = 0; gi < 16; gi++) begin : g_byte
        localparam int R = gi % 4;
        localparam int C = gi / 4;
        assign w_sr[gi] = w_in[4 * ((C - R + 4) % 4) + R];
        assign w_ak[gi] = inv_sbox(w_sr[gi]) ^ w_key[gi];
    end

    for (genvar gc = 0; gc < 4; gc++) begin : g_col
        logic [7:0] w_a0, w_a1, w_a2, w_a3;
        assign w_a0 = w_ak[4*gc];
        assign w_a1 = w_ak[4*gc+1];
        assign w_a2 = w_ak[4*gc+2];
        assign w_a3 = w_ak[4*gc+3];
        assign w_mc[4*gc]   = mul14(w_a0) ^ mul11(w_a1) ^ mul13(w_a2) ^ mul9(w_a3);
        assign w_mc[4*gc+1] = mul9(w_a0)  ^ mul14(w_a1) ^ mul11(w_a2) ^ mul13(w_a3);
        assign w_mc[4*gc+2] = mul13(w_a0) ^ mul9(w_a1)  ^ mul14(w_a2) ^ mul11(w_a3);
        assign w_mc[4*gc+3] = mul11(w_a0) ^ mul13(w_a1) ^ mul9(w_a2)  ^ mul14(w_a3);
    end

    assign o_state = i_last_round ? w_ak : w_mc;

endmodule

// File: rtl/aes128_inv_cipher_top.sv
// Iterative AES-128 inverse cipher: forward key walk to K10, then one inverse round per cycle.
// Optional K10 cache for a repeated key is enabled by defining AES128_INV_KEY_CACHE_EN.
module aes128_inv_cipher_top
    import aes128_inv_pkg::*;
(
    input  logic         clk_sys,
    input  logic         rst,
    input  logic [127:0] cipher_key,
    input  logic [127:0] cipher_text,
    input  logic         decipher_en,
    output logic [127:0] plain_text,
    output logic         plain_ready,
    output logic         busy
);
    fsm_e       r_fsm, w_next;
    state_t     r_blk, r_key;
    logic [3:0] r_rnd;
    state_t     w_fwd_key, w_inv_key, w_round;
    logic       w_start, w_done, w_hit;
    state_t     w_hit_key;

`ifdef AES128_INV_KEY_CACHE_EN
    state_t r_cached_key, r_cached_k10;
    logic   r_cache_valid;

    assign w_hit     = r_cache_valid && (cipher_key == r_cached_key);
    assign w_hit_key = r_cached_k10;

    // Key is recorded at start and K10 at ADDK; validity is only granted on completion.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            r_cached_key  <= '0;
            r_cached_k10  <= '0;
            r_cache_valid <= 1'b0;
        end else begin
            if (w_start && !w_hit) begin
                r_cached_key  <= cipher_key;
                r_cache_valid <= 1'b0;
            end
            if (r_fsm == ST_ADDK) r_cached_k10 <= r_key;
            if (w_done)           r_cache_valid <= 1'b1;
        end
    end
`else
    assign w_hit     = 1'b0;
    assign w_hit_key = '0;
`endif

    assign w_fwd_key = fwd_expand(r_key, rcon(r_rnd));
    assign w_inv_key = inv_expand(r_key, rcon((r_fsm == ST_ADDK) ? 4'd10 : r_rnd));

    aes128_inv_round u_round (
        .i_state      (r_blk),
        .i_key        (r_key),
        .i_last_round (r_rnd == 4'd0),
        .o_state      (w_round)
    );

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) r_fsm <= ST_IDLE;
        else     r_fsm <= w_next;
    end

    always_comb begin
        w_next = r_fsm;
        case (r_fsm)
            ST_IDLE:   if (decipher_en)      w_next = w_hit ? ST_ADDK : ST_KEYGEN;
            ST_KEYGEN: if (r_rnd == 4'd10)   w_next = ST_ADDK;
            ST_ADDK:                         w_next = ST_ROUND;
            ST_ROUND:  if (r_rnd == 4'd0)    w_next = ST_IDLE;
            default:                         w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy    = (r_fsm != ST_IDLE);
        w_start = (r_fsm == ST_IDLE) && decipher_en;
        w_done  = (r_fsm == ST_ROUND) && (r_rnd == 4'd0);
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            r_blk <= '0;
            r_key <= '0;
            r_rnd <= '0;
        end else begin
            case (r_fsm)
                ST_IDLE: if (decipher_en) begin
                    r_key <= w_hit ? w_hit_key : cipher_key;
                    r_blk <= cipher_text;
                    r_rnd <= 4'd1;
                end
                ST_KEYGEN: begin
                    r_key <= w_fwd_key;
                    r_rnd <= r_rnd + 4'd1;
                end
                ST_ADDK: begin
                    r_blk <= r_blk ^ r_key;
                    r_key <= w_inv_key;
                    r_rnd <= 4'd9;
                end
                ST_ROUND: begin
                    r_blk <= w_round;
                    r_key <= w_inv_key;
                    if (r_rnd != 4'd0) r_rnd <= r_rnd - 4'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            plain_text  <= '0;
            plain_ready <= 1'b0;
        end else begin
            plain_ready <= w_done;
            if (w_done) plain_text <= w_round;
        end
    end

endmodule

// File: tb/tb_aes128_inv_cipher_top.sv
// Directed bench for the AES-128 inverse cipher using FIPS-197 vectors.
module tb_aes128_inv_cipher_top;
    import aes128_inv_pkg::*;

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K10_B  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
`ifdef AES128_INV_KEY_CACHE_EN
    localparam int LAT_REPEAT = 11;
`else
    localparam int LAT_REPEAT = 21;
`endif

    logic         clk_sys = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] cipher_key = '0;
    logic [127:0] cipher_text = '0;
    logic         decipher_en = 1'b0;
    logic [127:0] plain_text;
    logic         plain_ready;
    logic         busy;

    int n_vec = 0;
    int n_err = 0;

    aes128_inv_cipher_top dut (
        .clk_sys     (clk_sys),
        .rst         (rst),
        .cipher_key  (cipher_key),
        .cipher_text (cipher_text),
        .decipher_en (decipher_en),
        .plain_text  (plain_text),
        .plain_ready (plain_ready),
        .busy        (busy)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives the start strobe so it is sampled at the next edge (E0).
    task automatic start(input logic [127:0] key, input logic [127:0] ct);
        @(negedge clk_sys);
        cipher_key  = key;
        cipher_text = ct;
        decipher_en = 1'b1;
        @(posedge clk_sys); #1;
        decipher_en = 1'b0;
    endtask

    // Counts edges after E0 until plain_ready; -1 if the budget runs out.
    task automatic run_wait(output int lat, output logic [127:0] k_addk,
                            output bit pt_held, input logic [127:0] hold);
        lat = -1; k_addk = '0; pt_held = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk_sys); #1;
            if (dut.r_fsm == ST_ADDK) k_addk = dut.r_key;
            if (plain_ready) begin lat = n; break; end
            if (plain_text !== hold) pt_held = 1'b0;
        end
    endtask

    initial begin
        int           lat, rdy_cnt, rdy_at;
        logic [127:0] kad, rdy_pt;
        bit           held;

        #1;
        chk("rst_busy",  busy, 0);
        chk("rst_ready", plain_ready, 0);
        chk("rst_pt",    plain_text, 0);
        repeat (2) @(posedge clk_sys);
        @(negedge clk_sys); rst = 1'b0;

        // C.1 run with extra strobes at E5 and E21 carrying a different ciphertext
        start(KEY_C1, CT_C1);
        rdy_cnt = 0; rdy_at = -1; rdy_pt = '0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk_sys);
            decipher_en = (n == 5 || n == 21);
            cipher_text = decipher_en ? CT_B : CT_C1;
            @(posedge clk_sys); #1;
            decipher_en = 1'b0;
            if (plain_ready) begin rdy_cnt++; rdy_at = n; rdy_pt = plain_text; end
        end
        chk("ign_count", rdy_cnt, 1);
        chk("ign_lat",   rdy_at, 21);
        chk("ign_pt",    rdy_pt, PT_C1);
        chk("ign_busy",  busy, 0);

        // Reset in the middle of a B run
        start(KEY_B, CT_B);
        repeat (14) @(posedge clk_sys);
        #1;
        chk("mid_busy_pre", busy, 1);
        rst = 1'b1; #1;
        chk("mid_busy",  busy, 0);
        chk("mid_ready", plain_ready, 0);
        chk("mid_pt",    plain_text, 0);
        @(negedge clk_sys); rst = 1'b0;

        start(KEY_C1, CT_C1);
        run_wait(lat, kad, held, 128'h0);
        chk("post_rst_lat", lat, 21);
        chk("post_rst_pt",  plain_text, PT_C1);

        // Back-to-back: C.1 then B restarted at the first idle edge
        start(KEY_C1, CT_C1);
        run_wait(lat, kad, held, PT_C1);
        chk("b2b_lat1", lat, LAT_REPEAT);
        chk("b2b_pt1",  plain_text, PT_C1);
        start(KEY_B, CT_B);
        chk("b2b_busy", busy, 1);
        run_wait(lat, kad, held, PT_C1);
        chk("b2b_held", held, 1);
        chk("b2b_k10",  kad, K10_B);
        chk("b2b_lat2", lat, 21);
        chk("b2b_pt2",  plain_text, PT_B);
        @(posedge clk_sys); #1;
        chk("b2b_pulse", plain_ready, 0);

`ifdef AES128_INV_KEY_CACHE_EN
        start(KEY_C1, CT_C1);
        run_wait(lat, kad, held, PT_B);
        chk("cache_miss_lat", lat, 21);
        chk("cache_miss_pt",  plain_text, PT_C1);
        start(KEY_C1, CT_C1);
        run_wait(lat, kad, held, PT_C1);
        chk("cache_hit_lat", lat, 11);
        chk("cache_hit_pt",  plain_text, PT_C1);
        start(KEY_B, CT_B);
        run_wait(lat, kad, held, PT_C1);
        chk("cache_chg_lat", lat, 21);
        chk("cache_chg_pt",  plain_text, PT_B);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
